// File: rtl/weight_fetch_if.sv
// Weight-fetch bundle: burst control, memory read port and PE-array stream.
// master = fetch engine side, slave = environment (memory + consumer + sequencer).
interface weight_fetch_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [31:0]      base_addr;
  logic [15:0]      num_words;
  logic             busy;
  logic             done;
  logic             mem_write_en;
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_data_out;
  logic             w_valid;
  logic             w_ready;
  logic [WIDTH-1:0] w_data;
  logic             w_last;

  modport master (
    input  start, base_addr, num_words,
    input  mem_data_out, w_ready,
    output busy, done, mem_write_en, mem_addr,
    output w_valid, w_data, w_last
  );

  modport slave (
    output start, base_addr, num_words,
    output mem_data_out, w_ready,
    input  busy, done, mem_write_en, mem_addr,
    input  w_valid, w_data, w_last
  );
endinterface

// File: rtl/weight_fetch.sv
// Burst read engine: weight RAM -> small FIFO -> valid/ready stream to PEs.
// Optional WFETCH_BYTE_SWAP_EN byte-reverses each word at FIFO input.
module weight_fetch #(
  parameter int WIDTH      = 64,
  parameter int LENGTH     = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  weight_fetch_if.master bus
);

  localparam int AW = $clog2(LENGTH);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_base;
  logic [15:0]   r_num;
  logic [15:0]   r_issued;
  logic          r_busy;
  logic          r_done;
  logic [31:0]   r_mem_addr;
  logic          r_issue_q;
  logic          r_issue_last_q;
  logic          r_pending;
  logic          r_pending_last;

  logic [WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic             r_fifo_last [FIFO_DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_count;

  logic             w_valid;
  logic             w_pop;
  logic [OW-1:0]    w_occ;
  logic             w_can_issue;
  logic [AW-1:0]    w_issue_addr;
  logic             w_issue_last;
  logic             w_head_last;
  logic [WIDTH-1:0] w_push_data;
  logic             w_unused;

  assign w_unused = ^bus.base_addr[31:AW];

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.w_ready;

  // Reserve a slot for every word still in the RAM pipeline.
  assign w_occ = OW'(r_count) + OW'(r_issue_q)
               + OW'(r_pending) - OW'(w_pop);
  assign w_can_issue  = (r_state == S_FETCH) && (w_occ < DEPTH_C);
  assign w_issue_addr = r_base + AW'(r_issued);
  assign w_issue_last = ((r_issued + 16'd1) == r_num);
  assign w_head_last  = r_fifo_last[r_rp];

  always_comb begin
    w_push_data = bus.mem_data_out;
`ifdef WFETCH_BYTE_SWAP_EN
    for (int i = 0; i < WIDTH / 8; i++) begin
      w_push_data[WIDTH-1-8*i -: 8] = bus.mem_data_out[8*i +: 8];
    end
`else
    w_push_data = bus.mem_data_out;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_num          <= '0;
      r_issued       <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_mem_addr     <= '0;
      r_issue_q      <= 1'b0;
      r_issue_last_q <= 1'b0;
      r_pending      <= 1'b0;
      r_pending_last <= 1'b0;
    end else begin
      r_done         <= 1'b0;
      r_issue_q      <= 1'b0;
      r_issue_last_q <= 1'b0;
      r_pending      <= r_issue_q;
      r_pending_last <= r_issue_last_q;
      unique case (r_state)
        S_IDLE: begin
          // A start during the done pulse is still part of the old burst.
          if (bus.start && !r_done) begin
            if (bus.num_words == '0) begin
              r_done <= 1'b1;
            end else begin
              r_base         <= bus.base_addr[AW-1:0];
              r_num          <= bus.num_words;
              r_issued       <= 16'd1;
              r_mem_addr     <= 32'(bus.base_addr[AW-1:0]);
              r_issue_q      <= 1'b1;
              r_issue_last_q <= (bus.num_words == 16'd1);
              r_busy         <= 1'b1;
              r_state        <= (bus.num_words == 16'd1) ?
                                S_DRAIN : S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_can_issue) begin
            r_mem_addr     <= 32'(w_issue_addr);
            r_issued       <= r_issued + 16'd1;
            r_issue_q      <= 1'b1;
            r_issue_last_q <= w_issue_last;
            if (w_issue_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (r_pending)
        r_wp <= (r_wp == PTR_MAX) ? '0 : r_wp + 1'b1;
      if (w_pop)
        r_rp <= (r_rp == PTR_MAX) ? '0 : r_rp + 1'b1;
      if (r_pending && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!r_pending && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_pending) begin
      r_fifo_data[r_wp] <= w_push_data;
      r_fifo_last[r_wp] <= r_pending_last;
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.mem_write_en = 1'b0;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.w_valid      = w_valid;
  assign bus.w_data       = w_valid ? r_fifo_data[r_rp] : '0;
  assign bus.w_last       = w_valid & w_head_last;

endmodule

// File: tb/tb_weight_fetch.sv
// Scoreboard bench for weight_fetch: RAM model, ready patterns, reset.
// Honors WFETCH_BYTE_SWAP_EN when compiled with it.
module tb_weight_fetch;
  localparam int W = 64;
  localparam int L = 4096;
`ifdef WFETCH_BYTE_SWAP_EN
  localparam logic [63:0] W0_EXP = 64'h0807060504030201;
`else
  localparam logic [63:0] W0_EXP = 64'h0102030405060708;
`endif

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_fetch_if #(.WIDTH(W)) bus ();

  weight_fetch #(
    .WIDTH(W),
    .LENGTH(L),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [63:0] ram [L];
  always @(posedge clk) bus.mem_data_out <= ram[bus.mem_addr[11:0]];

  int chk_cnt = 0;
  int err_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int rmode = 1;
  int rph = 0;
  logic [3:0] pat = 4'b1001;
  logic stall_prev = 1'b0;
  logic [63:0] prev_data;
  logic prev_last;
  exp_t exp_q[$];
  exp_t got_e;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int a);
    logic [63:0] v;
    logic [63:0] r;
    v = ram[a];
`ifdef WFETCH_BYTE_SWAP_EN
    r = {<<8{v}};
`else
    r = v;
`endif
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: bus.w_ready = 1'b0;
      1: bus.w_ready = 1'b1;
      default: begin
        bus.w_ready = pat[rph];
        rph = (rph + 1) % 4;
      end
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(bus.w_valid), 64'd1);
        chk("stall_data", bus.w_data, prev_data);
        chk("stall_last", 64'(bus.w_last), 64'(prev_last));
      end
      if (bus.w_valid && bus.w_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_pop", 64'd1, 64'd0);
        end else begin
          got_e = exp_q.pop_front();
          chk("pop_data", bus.w_data, got_e.data);
          chk("pop_last", 64'(bus.w_last), 64'(got_e.last));
        end
        pop_cnt++;
      end
      stall_prev = bus.w_valid && !bus.w_ready;
      prev_data  = bus.w_data;
      prev_last  = bus.w_last;
      if (bus.done) done_cnt++;
    end
  end

  task automatic run_burst(input int base, input int n, input bit seq,
                           input bit ign, input int lat);
    int e0;
    int d0;
    int p0;
    bit seen;
    exp_t e;
    d0 = done_cnt;
    p0 = pop_cnt;
    for (int i = 0; i < n; i++) begin
      e.last = (i == n - 1);
      e.data = exp_word((base + i) % L);
      exp_q.push_back(e);
    end
    bus.start     = 1'b1;
    bus.base_addr = 32'(base);
    bus.num_words = 16'(n);
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.start = 1'b0;
    chk("busy", 64'(bus.busy), 64'(n != 0));
    if (ign) begin
      bus.start     = 1'b1;
      bus.base_addr = 32'd2000;
      bus.num_words = 16'd16;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    if (seq) begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          @(posedge clk);
          #1;
        end
        chk("mem_addr", 64'(bus.mem_addr), 64'((base + i) % L));
        chk("valid_lat", 64'(bus.w_valid), 64'(i >= 2));
        if (base == 0 && i == 2) chk("word0", bus.w_data, W0_EXP);
      end
    end
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (lat >= 0) chk("done_lat", 64'(cyc - e0), 64'(lat));
    @(posedge clk);
    #1;
    chk("done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("pops", 64'(pop_cnt - p0), 64'(n));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int p0;
    int d0;
    for (int i = 0; i < L; i++)
      ram[i] = {16'hC0DE, 4'h0, 12'(i), 32'(i * 7 + 3) ^ 32'h9E3779B9};
    ram[0] = 64'h0102030405060708;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_valid", 64'(bus.w_valid), 64'd0);
    chk("rst_last", 64'(bus.w_last), 64'd0);
    chk("rst_data", bus.w_data, 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_we", 64'(bus.mem_write_en), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    rmode = 1;
    run_burst(0, 4, 1'b1, 1'b0, 6);

    rmode = 2;
    run_burst(0, 8, 1'b0, 1'b0, -1);
    rmode = 1;

    run_burst(4094, 4, 1'b1, 1'b0, 6);

    run_burst(500, 0, 1'b0, 1'b0, 0);
    chk("zero_addr", 64'(bus.mem_addr), 64'd1);
    chk("zero_valid", 64'(bus.w_valid), 64'd0);

    rmode = 2;
    run_burst(100, 6, 1'b0, 1'b1, -1);
    rmode = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("ign_busy", 64'(bus.busy), 64'd0);
    chk("ign_valid", 64'(bus.w_valid), 64'd0);
    chk("ign_addr", 64'(bus.mem_addr), 64'd105);

    p0 = pop_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      got_e.last = (i == 9);
      got_e.data = exp_word(300 + i);
      exp_q.push_back(got_e);
    end
    bus.start     = 1'b1;
    bus.base_addr = 32'd300;
    bus.num_words = 16'd10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (pop_cnt - p0 >= 3) break;
    end
    chk("pop3", 64'(pop_cnt - p0 >= 3), 64'd1);
    rmode = 0;
    rst = 1'b1;
    #1;
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_valid", 64'(bus.w_valid), 64'd0);
    chk("mrst_last", 64'(bus.w_last), 64'd0);
    chk("mrst_data", bus.w_data, 64'd0);
    chk("mrst_addr", 64'(bus.mem_addr), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_valid", 64'(bus.w_valid), 64'd0);
    end
    chk("mrst_no_done", 64'(done_cnt - d0), 64'd0);
    rmode = 1;
    @(posedge clk);
    #1;
    run_burst(700, 2, 1'b0, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
